hsid_mse_batch_ctrl: RTL and testbench

Sequencer for the 2-element batched squared-difference datapath. It accepts one vector pair per job as a stream of packed words, issues them to the datapath with valid/ready flow control, and tags each issue through the datapath's fixed latency. It accumulates the per-word sums and returns the total sum of squared differences plus the element count. It sits between the pixel/vector fetch logic and the batch datapath.

---
 rtl/hsid_mse_batch_ctrl.sv | 146 ++++++++++++++
 tb/tb_hsid_mse_batch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsid_mse_batch_ctrl.sv
// Job sequencer for the 2-element batched squared-difference datapath.
// Streams one vector pair per job into the datapath, tracks each issued word
// through the datapath's fixed latency with a tag shift register, accumulates
// the returned per-word sums and presents the job total plus element count.
module hsid_mse_batch_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int WORD_WIDTH     = DATA_WIDTH * 2,
  parameter int DATA_WIDTH_SUM = DATA_WIDTH * 2,
  parameter int LEN_WIDTH      = 8,
  parameter int DP_LATENCY     = 2,
  parameter int ACC_WIDTH      = DATA_WIDTH_SUM + LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      vctr_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_WIDTH-1:0]     in_vctr_1,
  input  logic [WORD_WIDTH-1:0]     in_vctr_2,
  output logic [WORD_WIDTH-1:0]     dp_vctr_1,
  output logic [WORD_WIDTH-1:0]     dp_vctr_2,
  input  logic [DATA_WIDTH_SUM-1:0] dp_sum_in,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [ACC_WIDTH-1:0]      result_sum,
  output logic [LEN_WIDTH:0]        result_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   issue_cnt;
  logic [LEN_WIDTH-1:0]   recv_cnt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [DP_LATENCY-1:0]  tag;

  logic                   accept;
  logic                   tag_out;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [LEN_WIDTH-1:0]   recv_next;
  logic [LEN_WIDTH-1:0]   issue_next;

  // in_ready depends only on state and issue count so the upstream fetch
  // logic never sees a combinational path from its own in_valid.
  assign in_ready     = (state == RUN) && (issue_cnt < len_q);
  assign accept       = in_valid && in_ready;
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  // Idle cycles drive zeros so the datapath output is a clean zero on bubbles.
  assign dp_vctr_1 = accept ? in_vctr_1 : '0;
  assign dp_vctr_2 = accept ? in_vctr_2 : '0;

  // The oldest tag marks the cycle in which dp_sum_in belongs to an issued word.
  assign tag_out    = tag[DP_LATENCY-1];
  assign issue_next = issue_cnt + LEN_WIDTH'(1);

  // Next accumulator / receive count for the word leaving the datapath this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    acc_next  = acc;
    recv_next = recv_cnt;
    if (tag_out && ((state == RUN) || (state == DRAIN))) begin
      acc_next  = acc + ACC_WIDTH'(dp_sum_in);
      recv_next = recv_cnt + LEN_WIDTH'(1);
    end
  end

  // Job FSM, tag pipe, counters, accumulator and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      state        <= IDLE;
      len_q        <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      acc          <= '0;
      tag          <= '0;
      result_sum   <= '0;
      result_count <= '0;
    end else begin
      tag[0] <= accept;
      for (int i = 1; i < DP_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= vctr_len;
            acc       <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            if (vctr_len == '0) begin
              result_sum   <= '0;
              result_count <= '0;
              state        <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          acc      <= acc_next;
          recv_cnt <= recv_next;
          if (accept) begin
            issue_cnt <= issue_next;
            if (issue_next == len_q) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          acc      <= acc_next;
          recv_cnt <= recv_next;
          // Leave in the same cycle as the final accumulate so the result
          // appears DP_LATENCY+1 cycles after the last accepted beat.
          if (recv_next == len_q) begin
            result_sum   <= acc_next;
            result_count <= {len_q, 1'b0};
            state        <= DONE;
          end
        end

        DONE: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsid_mse_batch_ctrl.sv
// Testbench for hsid_mse_batch_ctrl: a 2-cycle squared-difference datapath
// model feeds dp_sum_in; directed jobs push their expected result into a
// scoreboard queue that a negedge monitor pops on every result handshake.
module tb_hsid_mse_batch_ctrl;

  localparam int DW  = 16;
  localparam int WW  = 32;
  localparam int SW  = 32;
  localparam int LW  = 8;
  localparam int LAT = 2;
  localparam int AW  = SW + LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] vctr_len;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_vctr_1;
  logic [WW-1:0] in_vctr_2;
  logic [WW-1:0] dp_vctr_1;
  logic [WW-1:0] dp_vctr_2;
  logic [SW-1:0] dp_sum_in;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [AW-1:0] result_sum;
  logic [LW:0]   result_count;

  hsid_mse_batch_ctrl #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DP_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vctr_len(vctr_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vctr_1(in_vctr_1), .in_vctr_2(in_vctr_2),
    .dp_vctr_1(dp_vctr_1), .dp_vctr_2(dp_vctr_2), .dp_sum_in(dp_sum_in),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_sum(result_sum), .result_count(result_count)
  );

  always #5 clk = ~clk;

  // Datapath model: sum of squared element differences, two register stages.
  function automatic logic [SW-1:0] sq_sum(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [DW-1:0] d0, d1;
    d0 = (a[15:0]  >= b[15:0])  ? a[15:0]  - b[15:0]  : b[15:0]  - a[15:0];
    d1 = (a[31:16] >= b[31:16]) ? a[31:16] - b[31:16] : b[31:16] - a[31:16];
    return ({16'd0, d0} * {16'd0, d0}) + ({16'd0, d1} * {16'd0, d1});
  endfunction

  logic [SW-1:0] dp_s0 = '0;
  logic [SW-1:0] dp_s1 = '0;
  always @(posedge clk) begin
    dp_s0 <= sq_sum(dp_vctr_1, dp_vctr_2);
    dp_s1 <= dp_s0;
  end
  assign dp_sum_in = dp_s1;

  typedef struct {
    logic [AW-1:0] sum;
    logic [LW:0]   count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   first_valid_cyc = 0;
  int   ready_seen = 0;
  logic rv_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency timestamp, in_ready activity, scoreboard compare on handshake.
  always @(negedge clk) begin
    if (in_ready) ready_seen++;
    if (result_valid && !rv_prev) first_valid_cyc = cyc;
    rv_prev = result_valid;
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(result_sum), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_sum", 64'(result_sum), 64'(e.sum));
        check("sb_count", 64'(result_count), 64'(e.count));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a job and feed len words; vpat gives the in_valid pattern (patlen 0 = continuous).
  task automatic run_job(input logic [LW-1:0] len, input logic [WW-1:0] v1, input logic [WW-1:0] v2,
                         input logic [6:0] vpat, input int patlen, input bit push,
                         input logic [AW-1:0] exp_sum, output int acc_cyc);
    int beats;
    int i;
    exp_t e;
    acc_cyc = 0;
    if (push) begin
      e.sum   = exp_sum;
      e.count = {len, 1'b0};
      exp_q.push_back(e);
    end
    tick();
    start    = 1'b1;
    vctr_len = len;
    tick();
    start = 1'b0;
    beats = 0;
    i     = 0;
    while ((beats < int'(len)) && (i < 200)) begin
      in_valid  = (patlen == 0) ? 1'b1 : vpat[i % patlen];
      in_vctr_1 = v1;
      in_vctr_2 = v2;
      @(negedge clk);
      if (in_valid && in_ready) begin
        beats++;
        acc_cyc = cyc;
        check("dp_vctr_1_issue", 64'(dp_vctr_1), 64'(v1));
        check("dp_vctr_2_issue", 64'(dp_vctr_2), 64'(v2));
      end else if (in_ready) begin
        check("dp_vctr_1_bubble", 64'(dp_vctr_1), 64'h0);
      end
      tick();
      i++;
    end
    in_valid = 1'b0;
    if (beats < int'(len)) check("feed_timeout", 64'(beats), 64'(len));
  endtask

  // Wait (bounded) for the monitor to consume all expected results, then pass the handshake edge.
  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check("result_timeout", 64'(exp_q.size()), 64'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac;
    rst = 1'b1; start = 1'b0; vctr_len = '0; in_valid = 1'b0;
    in_vctr_1 = '0; in_vctr_2 = '0; result_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_result_valid", 64'(result_valid), 64'h0);
    check("rst_result_sum", 64'(result_sum), 64'h0);
    check("rst_result_count", 64'(result_count), 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // len=1: (3-1)^2 + (1-4)^2 = 13
    run_job(8'd1, 32'h0003_0001, 32'h0001_0004, 7'h0, 0, 1'b1, 40'd13, ac);
    wait_drain();
    check("lat_len1", 64'(first_valid_cyc - ac), 64'd3);

    // len=4 continuous: 4 * (9+9) = 72, in_ready high exactly 4 cycles
    ready_seen = 0;
    run_job(8'd4, 32'h0005_0005, 32'h0002_0002, 7'h0, 0, 1'b1, 40'd72, ac);
    wait_drain();
    check("lat_len4", 64'(first_valid_cyc - ac), 64'd3);
    check("ready_cycles_len4", 64'(ready_seen), 64'd4);

    // Same job with bubbles 1,0,0,1,0,1,1
    run_job(8'd4, 32'h0005_0005, 32'h0002_0002, 7'b1101001, 7, 1'b1, 40'd72, ac);
    wait_drain();
    check("lat_bubbles", 64'(first_valid_cyc - ac), 64'd3);

    // len=0: DONE the next cycle with zero result, in_ready never raised
    ready_seen = 0;
    begin
      exp_t e;
      e.sum = '0;
      e.count = '0;
      exp_q.push_back(e);
    end
    tick();
    start = 1'b1; vctr_len = 8'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("len0_valid", 64'(result_valid), 64'h1);
    check("len0_sum", 64'(result_sum), 64'h0);
    check("len0_count", 64'(result_count), 64'h0);
    tick();
    @(negedge clk);
    check("len0_idle", 64'(busy), 64'h0);
    check("len0_ready_never", 64'(ready_seen), 64'h0);

    // Back-pressure in DONE with a start pulse that must be ignored
    result_ready = 1'b0;
    run_job(8'd1, 32'h0003_0001, 32'h0001_0004, 7'h0, 0, 1'b1, 40'd13, ac);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    check("hold_reach_done", 64'(result_valid), 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      start    = (k == 2);
      vctr_len = 8'd9;
      @(negedge clk);
      check("hold_valid", 64'(result_valid), 64'h1);
      check("hold_sum", 64'(result_sum), 64'd13);
      check("hold_count", 64'(result_count), 64'd2);
    end
    tick();
    start = 1'b0;
    result_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("post_hs_valid", 64'(result_valid), 64'h0);
    check("post_hs_busy", 64'(busy), 64'h0);

    // Next start accepted: len=2, (0-2)^2 + (4-0)^2 = 20 per word -> 40
    run_job(8'd2, 32'h0004_0000, 32'h0000_0002, 7'h0, 0, 1'b1, 40'd40, ac);
    wait_drain();

    // Reset mid-DRAIN with two beats in flight
    run_job(8'd4, 32'h0005_0005, 32'h0002_0002, 7'h0, 0, 1'b0, 40'd0, ac);
    check("pre_rst_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_valid", 64'(result_valid), 64'h0);
    check("midrst_sum", 64'(result_sum), 64'h0);
    check("midrst_count", 64'(result_count), 64'h0);
    check("midrst_dp", 64'(dp_vctr_1), 64'h0);

    // Following job must see no stale sums: (0-3)^2 = 9
    run_job(8'd1, 32'h0000_0000, 32'h0000_0003, 7'h0, 0, 1'b1, 40'd9, ac);
    wait_drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
